// File: rtl/block_variance_calc.sv
// rtl/block_variance_calc.sv - per-block mean/variance statistics stage
//
// Purpose:
//   Accumulates one block of TOTAL_SAMPLES unsigned pixel samples, then produces
//   the block mean floor(sum/N) and variance floor(sumsq/N) - mean^2 through a
//   two-stage result pipe that is independent of the accumulation FSM.
//
// Ports:
//   clk            - rising-edge clock
//   rst_n          - asynchronous active-low reset
//   data_in        - pixel sample
//   data_valid     - data_in valid this cycle
//   start_data     - first sample of block (qualified by data_valid)
//   end_data       - last sample of block (qualified by data_valid)
//   mean           - block mean
//   variance       - block variance
//   variance_ready - one-cycle pulse, mean/variance/len_error valid while high
//   len_error      - closed block length differed from TOTAL_SAMPLES
//
// Optional feature macro: BLOCK_LEN_CHECK_EN (enables len_error; tied 0 otherwise)

module block_variance_calc #(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_SAMPLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  input  logic                    start_data,
  input  logic                    end_data,
  output logic [DATA_WIDTH-1:0]   mean,
  output logic [2*DATA_WIDTH-1:0] variance,
  output logic                    variance_ready,
  output logic                    len_error
);

  localparam int LOG2N = $clog2(TOTAL_SAMPLES);
  localparam int SW    = DATA_WIDTH + LOG2N;
  localparam int QW    = 2*DATA_WIDTH + LOG2N;

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e                  state_q, state_d;
  logic [SW-1:0]           sum_q, sum_d;
  logic [QW-1:0]           sumsq_q, sumsq_d;

  logic                    p1_valid_q, p1_valid_d;
  logic [DATA_WIDTH-1:0]   mean_r_q, mean_r_d;
  logic [2*DATA_WIDTH-1:0] ex2_r_q, ex2_r_d;

  logic                    variance_ready_q, variance_ready_d;
  logic [DATA_WIDTH-1:0]   mean_q, mean_d;
  logic [2*DATA_WIDTH-1:0] variance_q, variance_d;

  logic                    v_start;
  logic                    v_end;
  logic                    close_fire;
  logic [2*DATA_WIDTH-1:0] x_ext;
  logic [2*DATA_WIDTH-1:0] x_sq;
  logic [SW-1:0]           x_sum_ext;
  logic [QW-1:0]           x_sq_ext;
  logic [2*DATA_WIDTH-1:0] mean_r_ext;

`ifdef BLOCK_LEN_CHECK_EN
  localparam int CW = LOG2N + 1;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    len_r_q, len_r_d;
  logic                    len_error_q, len_error_d;
`endif

  always_comb begin
    v_start    = data_valid & start_data;
    v_end      = data_valid & end_data;
    x_ext      = {{DATA_WIDTH{1'b0}}, data_in};
    x_sq       = x_ext * x_ext;
    x_sum_ext  = {{LOG2N{1'b0}}, data_in};
    x_sq_ext   = {{LOG2N{1'b0}}, x_sq};

    state_d    = state_q;
    sum_d      = sum_q;
    sumsq_d    = sumsq_q;
    close_fire = 1'b0;

    // A start always (re)opens a block with this sample, discarding any partial one.
    if (v_start) begin
      sum_d   = x_sum_ext;
      sumsq_d = x_sq_ext;
      state_d = ACCUM;
    end else if (data_valid && state_q == ACCUM) begin
      sum_d   = sum_q + x_sum_ext;
      sumsq_d = sumsq_q + x_sq_ext;
    end

    // The closing sample is already folded into sum_d/sumsq_d, so the pipe takes those.
    if (v_end && (v_start || state_q == ACCUM)) begin
      close_fire = 1'b1;
      state_d    = IDLE;
    end

`ifdef BLOCK_LEN_CHECK_EN
    cnt_d = cnt_q;
    if (v_start) begin
      cnt_d = CW'(1);
    end else if (data_valid && state_q == ACCUM) begin
      cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
    end
    len_r_d     = close_fire ? (cnt_d != CW'(TOTAL_SAMPLES)) : len_r_q;
    len_error_d = p1_valid_q ? len_r_q : len_error_q;
`endif

    // Stage 1: divide by N via truncating shift.
    p1_valid_d = close_fire;
    mean_r_d   = close_fire ? sum_d[SW-1:LOG2N]   : mean_r_q;
    ex2_r_d    = close_fire ? sumsq_d[QW-1:LOG2N] : ex2_r_q;

    // Stage 2: E[x^2] - E[x]^2; cannot go negative with floor-divided terms.
    mean_r_ext       = {{DATA_WIDTH{1'b0}}, mean_r_q};
    variance_ready_d = p1_valid_q;
    mean_d           = p1_valid_q ? mean_r_q : mean_q;
    variance_d       = p1_valid_q ? (ex2_r_q - mean_r_ext * mean_r_ext) : variance_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      sum_q            <= '0;
      sumsq_q          <= '0;
      p1_valid_q       <= 1'b0;
      mean_r_q         <= '0;
      ex2_r_q          <= '0;
      variance_ready_q <= 1'b0;
      mean_q           <= '0;
      variance_q       <= '0;
`ifdef BLOCK_LEN_CHECK_EN
      cnt_q            <= '0;
      len_r_q          <= 1'b0;
      len_error_q      <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      sum_q            <= sum_d;
      sumsq_q          <= sumsq_d;
      p1_valid_q       <= p1_valid_d;
      mean_r_q         <= mean_r_d;
      ex2_r_q          <= ex2_r_d;
      variance_ready_q <= variance_ready_d;
      mean_q           <= mean_d;
      variance_q       <= variance_d;
`ifdef BLOCK_LEN_CHECK_EN
      cnt_q            <= cnt_d;
      len_r_q          <= len_r_d;
      len_error_q      <= len_error_d;
`endif
    end
  end

  assign mean           = mean_q;
  assign variance       = variance_q;
  assign variance_ready = variance_ready_q;
`ifdef BLOCK_LEN_CHECK_EN
  assign len_error      = len_error_q;
`else
  assign len_error      = 1'b0;
`endif

endmodule

// File: tb/tb_block_variance_calc.sv
// tb/tb_block_variance_calc.sv - self-checking bench for block_variance_calc

module tb_block_variance_calc;

  localparam int DW = 8;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          start_data = 1'b0;
  logic          end_data = 1'b0;
  logic [DW-1:0]   mean;
  logic [2*DW-1:0] variance;
  logic            variance_ready;
  logic            len_error;

  block_variance_calc #(.DATA_WIDTH(DW), .TOTAL_SAMPLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .start_data(start_data), .end_data(end_data), .mean(mean),
    .variance(variance), .variance_ready(variance_ready), .len_error(len_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mean;
    int var_v;
    bit len;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   blk[$];
  bit   in_blk;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   hold_mean;
  int   hold_var;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, got, expv);
    end
  endtask

  // Reference: statistics straight from the block's sample list.
  task automatic close_block();
    longint s, sq, m, e2;
    exp_t   e;
    s = 0; sq = 0;
    foreach (blk[i]) begin
      s  += blk[i];
      sq += blk[i] * blk[i];
    end
    m  = s / N;
    e2 = sq / N;
    e.mean  = int'(m);
    e.var_v = int'(e2 - m * m);
`ifdef BLOCK_LEN_CHECK_EN
    e.len   = (blk.size() != N);
`else
    e.len   = 1'b0;
`endif
    e.due   = cyc + 2;
    exp_q.push_back(e);
    in_blk = 1'b0;
    blk.delete();
  endtask

  // One cycle: check outputs at the falling edge, then present the next inputs.
  task automatic tick();
    bit   exp_rdy;
    exp_t e;
    @(negedge clk);
    cyc++;
    exp_rdy = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    chk("variance_ready", {31'b0, variance_ready}, {31'b0, exp_rdy});
    if (exp_rdy) begin
      e = exp_q.pop_front();
      hold_mean = e.mean;
      hold_var  = e.var_v;
      chk("len_error", {31'b0, len_error}, {31'b0, e.len});
    end
    chk("mean", {24'b0, mean}, hold_mean);
    chk("variance", {16'b0, variance}, hold_var);
  endtask

  task automatic drive(input bit v, input bit s, input bit e, input int x);
    tick();
    data_valid = v;
    start_data = s;
    end_data   = e;
    data_in    = DW'(x);
    if (v) begin
      if (s) begin
        blk.delete();
        blk.push_back(x);
        in_blk = 1'b1;
      end else if (in_blk) begin
        blk.push_back(x);
      end
      if (e && in_blk) close_block();
    end
  endtask

  // Invalid cycle with random junk on the qualifiers, which must be ignored.
  task automatic gap();
    drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
  endtask

  task automatic idle(input int k);
    repeat (k) gap();
  endtask

  // mode 0 constant, 1 alternating 0/255, 2 ramp, 3 random
  task automatic send_block(input int n, input int mode, input int val, input bit gaps, input bit close);
    int x;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       x = val;
        1:       x = (i % 2) ? 255 : 0;
        2:       x = i;
        default: x = $urandom_range(0, 255);
      endcase
      if (gaps && $urandom_range(0, 3) == 0) gap();
      drive(1'b1, i == 0, close && (i == n - 1), x);
    end
  endtask

  task automatic do_reset();
    tick();
    rst_n      = 1'b0;
    data_valid = 1'b0;
    start_data = 1'b0;
    end_data   = 1'b0;
    exp_q.delete();
    blk.delete();
    in_blk    = 1'b0;
    hold_mean = 0;
    hold_var  = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0; hold_mean = 0; hold_var = 0; in_blk = 1'b0;

    // Reset state
    tick();
    tick();
    rst_n = 1'b1;
    idle(2);

    // T1 constant block
    send_block(64, 0, 100, 1'b0, 1'b1);
    idle(3);
    // T2 alternating extremes
    send_block(64, 1, 0, 1'b0, 1'b1);
    idle(3);
    // T3 ramp then an immediately following block
    send_block(64, 2, 0, 1'b0, 1'b1);
    send_block(64, 3, 0, 1'b0, 1'b1);
    idle(3);
    // T4 partial block abandoned by a restart
    send_block(10, 0, 7, 1'b0, 1'b0);
    send_block(64, 0, 50, 1'b0, 1'b1);
    idle(3);
    // T5 reset mid-block, then reset mid-pipe
    send_block(30, 0, 9, 1'b0, 1'b0);
    do_reset();
    send_block(64, 0, 9, 1'b0, 1'b1);
    idle(3);
    send_block(64, 3, 0, 1'b0, 1'b1);
    do_reset();
    idle(3);
    // T6 short block and full block with invalid gaps inside
    send_block(41, 3, 0, 1'b1, 1'b1);
    send_block(64, 3, 0, 1'b1, 1'b1);
    idle(3);

    // Back-to-back single-sample blocks, and start+end closing a partial block
    repeat (3) drive(1'b1, 1'b1, 1'b1, $urandom_range(0, 255));
    send_block(5, 3, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 200);
    // Valid samples and end_data outside a block are dropped
    drive(1'b1, 1'b0, 1'b1, 77);
    drive(1'b1, 1'b0, 1'b0, 33);
    idle(3);

    // Random blocks
    repeat (20) begin
      int n;
      n = ($urandom_range(0, 1) == 1) ? N : $urandom_range(1, N);
      send_block(n, 3, 0, 1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(5);
    chk("pending_results", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
